uart_rx8: RTL and testbench

Serial receive stage downstream of the eight-byte UART transmitter `tx8`. It samples an 8N1 serial line, recovers bytes, and reassembles them into an eight-byte frame d0..d7. It presents the frame as parallel registers with a one-cycle valid pulse. It is the loopback/consumer side of the same link, running at the same CLKFREQ/BAUD pair.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx8_if.sv | 24 ++
 rtl/uart_rx_byte.sv | 153 +++++++++++++++
 rtl/uart_rx8.sv | 92 +++++++++
 tb/tb_uart_rx8.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive (uart_rx8) and transmit (tx8) sides.
//   uart_state_t : receiver FSM states
//   baud_cnt()   : clock cycles per bit for a CLKFREQ/BAUD pair
//   FRAME_BYTES  : bytes per reassembled frame
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_t;

    localparam int FRAME_BYTES = 8;

    function automatic int baud_cnt(input int clkfreq, input int baud);
        return clkfreq / baud;
    endfunction

endpackage

// File: rtl/uart_rx8_if.sv
// Frame/byte output bundle of uart_rx8.
//   d0..d7      : last complete frame, d0 = first byte after alignment
//   frame_valid : one-cycle pulse when d0..d7 update
//   byte_data   : last accepted byte
//   byte_valid  : one-cycle pulse per accepted byte
//   frame_err   : one-cycle pulse on a bad stop bit
// master = receiver side, slave = consumer side.
interface uart_rx8_if;
    logic [7:0] d0, d1, d2, d3, d4, d5, d6, d7;
    logic       frame_valid;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       frame_err;

    modport master (
        output d0, d1, d2, d3, d4, d5, d6, d7,
        output frame_valid, byte_data, byte_valid, frame_err
    );

    modport slave (
        input d0, d1, d2, d3, d4, d5, d6, d7,
        input frame_valid, byte_data, byte_valid, frame_err
    );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-FF synchroniser, falling-edge start detect, baud
// timer, LSB-first shift register and idle-line timer.
//   clk, rst      : system clock, async active-high reset
//   rx            : raw serial line (idle high)
//   byte_data     : last accepted byte (registered)
//   byte_valid    : one-cycle pulse per accepted byte (registered)
//   frame_err     : one-cycle pulse on a bad stop bit (registered)
//   byte_done     : stop bit sampled good this cycle (byte_valid follows next cycle)
//   byte_next     : shift register contents, valid with byte_done
//   idle_timeout  : line has been idle for IDLE_BITS bit periods
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge, idle timer running
// START | timing to mid start bit to confirm it
// DATA  | sampling 8 data bits at mid-bit
// STOP  | timing to mid stop bit
// BREAK | bad stop bit seen, waiting for the line to return high
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKFREQ   = 50_000_000,
    parameter int BAUD      = 115_200,
    parameter int IDLE_BITS = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       byte_done,
    output logic [7:0] byte_next,
    output logic       idle_timeout
);
    localparam int BAUD_CNT   = baud_cnt(CLKFREQ, BAUD);
    localparam int HALF_CNT   = BAUD_CNT / 2;
    localparam int IDLE_LIMIT = IDLE_BITS * BAUD_CNT;
    localparam int CNT_W      = (BAUD_CNT > 2) ? $clog2(BAUD_CNT) : 1;
    localparam int IDLE_W     = $clog2(IDLE_LIMIT + 1);

    // Baud timer is a down-counter; the sample happens at terminal count 0.
    // Loading HALF on START entry puts the start sample HALF cycles later;
    // reloading BAUD_CNT-1 at each sample spaces the rest one bit apart.
    localparam logic [CNT_W-1:0]  HALF_LD  = CNT_W'(HALF_CNT);
    localparam logic [CNT_W-1:0]  BIT_LD   = CNT_W'(BAUD_CNT - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_LIMIT);

    uart_state_t       state;
    logic              sync1;
    logic              rx_s;
    logic              rx_d;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;
    logic [IDLE_W-1:0] idle_cnt;
    logic              fall;

    assign fall         = rx_d & ~rx_s;
    assign byte_done    = (state == STOP) && (cnt == '0) && rx_s;
    assign byte_next    = shift;
    assign idle_timeout = (state == IDLE) && (idle_cnt == IDLE_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sync1      <= 1'b1;
            rx_s       <= 1'b1;
            rx_d       <= 1'b1;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            idle_cnt   <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync1      <= rx;
            rx_s       <= sync1;
            rx_d       <= rx_s;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;

            case (state)
                IDLE: begin
                    if (fall) begin
                        state    <= START;
                        cnt      <= HALF_LD;
                        idle_cnt <= '0;
                    end else if (rx_s && (idle_cnt != IDLE_MAX)) begin
                        idle_cnt <= idle_cnt + IDLE_W'(1);
                    end
                end

                START: begin
                    if (cnt == '0) begin
                        if (!rx_s) begin
                            state   <= DATA;
                            cnt     <= BIT_LD;
                            bit_idx <= '0;
                        end else begin
                            // Line back high at mid start bit: a glitch.
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                DATA: begin
                    if (cnt == '0) begin
                        shift <= {rx_s, shift[7:1]};
                        cnt   <= BIT_LD;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                STOP: begin
                    if (cnt == '0) begin
                        // Returning to IDLE at mid stop bit leaves half a bit
                        // to catch a start bit that follows immediately.
                        if (rx_s) begin
                            byte_data  <= shift;
                            byte_valid <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                BREAK: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_rx8.sv
// Eight-byte frame receiver. Bytes from uart_rx_byte are collected into a
// shadow array; the eighth byte loads d0..d7 all at once with frame_valid.
// A bad stop bit or an idle line of IDLE_BITS bit periods realigns the frame
// so the next byte lands in d0.
//   clk, rst : system clock, async active-high reset
//   UART_rx  : serial line, 8N1, LSB first, idle high
//   bus      : frame/byte outputs (uart_rx8_if.master)
module uart_rx8
    import uart_pkg::*;
#(
    parameter int CLKFREQ   = 50_000_000,
    parameter int BAUD      = 115_200,
    parameter int IDLE_BITS = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       UART_rx,
    uart_rx8_if.master bus
);
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       frame_err;
    logic       byte_done;
    logic [7:0] byte_next;
    logic       idle_timeout;

    logic [2:0] idx;
    logic [7:0] shadow [0:FRAME_BYTES-2];

    uart_rx_byte #(
        .CLKFREQ   (CLKFREQ),
        .BAUD      (BAUD),
        .IDLE_BITS (IDLE_BITS)
    ) u_byte (
        .clk          (clk),
        .rst          (rst),
        .rx           (UART_rx),
        .byte_data    (byte_data),
        .byte_valid   (byte_valid),
        .frame_err    (frame_err),
        .byte_done    (byte_done),
        .byte_next    (byte_next),
        .idle_timeout (idle_timeout)
    );

    assign bus.byte_data  = byte_data;
    assign bus.byte_valid = byte_valid;
    assign bus.frame_err  = frame_err;

    // Keyed off byte_done (the stop-sample cycle) so frame_valid and d0..d7
    // register on the same edge as the eighth byte_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx             <= '0;
            bus.frame_valid <= 1'b0;
            bus.d0          <= '0;
            bus.d1          <= '0;
            bus.d2          <= '0;
            bus.d3          <= '0;
            bus.d4          <= '0;
            bus.d5          <= '0;
            bus.d6          <= '0;
            bus.d7          <= '0;
            for (int i = 0; i < FRAME_BYTES - 1; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            bus.frame_valid <= 1'b0;
            if (byte_done) begin
                if (idx == 3'(FRAME_BYTES - 1)) begin
                    bus.d0          <= shadow[0];
                    bus.d1          <= shadow[1];
                    bus.d2          <= shadow[2];
                    bus.d3          <= shadow[3];
                    bus.d4          <= shadow[4];
                    bus.d5          <= shadow[5];
                    bus.d6          <= shadow[6];
                    bus.d7          <= byte_next;
                    bus.frame_valid <= 1'b1;
                    idx             <= '0;
                end else begin
                    shadow[idx] <= byte_next;
                    idx         <= idx + 3'd1;
                end
            end else if (frame_err || idle_timeout) begin
                // Partial frame is dropped simply by restarting at index 0.
                idx <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx8.sv
module tb_uart_rx8;
    import uart_pkg::*;

    localparam int CLKFREQ   = 1_600_000;
    localparam int BAUD      = 100_000;
    localparam int IDLE_BITS = 12;
    localparam int B         = CLKFREQ / BAUD;   // 16 cycles per bit

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic UART_rx = 1'b1;

    uart_rx8_if bus();

    uart_rx8 #(
        .CLKFREQ   (CLKFREQ),
        .BAUD      (BAUD),
        .IDLE_BITS (IDLE_BITS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .UART_rx (UART_rx),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int n_bv  = 0;
    int n_fv  = 0;
    int n_err = 0;
    logic [63:0] d_last = '0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap_bits;
        int         exp_bv;
        int         exp_err;
        int         exp_fv;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [63:0] d_word();
        return {bus.d7, bus.d6, bus.d5, bus.d4, bus.d3, bus.d2, bus.d1, bus.d0};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Pulse counters plus two invariants: d0..d7 only move with frame_valid,
    // and frame_valid only ever accompanies a byte_valid.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.byte_valid)  n_bv++;
            if (bus.frame_valid) n_fv++;
            if (bus.frame_err)   n_err++;
            if (bus.frame_valid) check("fv_with_bv", 64'(bus.byte_valid), 64'd1);
            if (d_word() != d_last) check("d_change_needs_fv", 64'(bus.frame_valid), 64'd1);
        end
        d_last = d_word();
    end

    task automatic send_bit(input logic b);
        #1 UART_rx = b;
        repeat (B) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] data, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
        send_bit(stop);
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    function automatic void add(input logic [7:0] data, input logic stop, input int gap,
                                input int bv, input int err, input int fv);
        vec_t v;
        v.data = data; v.stop = stop; v.gap_bits = gap;
        v.exp_bv = bv; v.exp_err = err; v.exp_fv = fv;
        vecs.push_back(v);
    endfunction

    initial begin
        int bv0, fv0, err0;
        logic [63:0] exp_d;
        logic [7:0]  b;

        // Clean frame 0x10..0x87
        for (int i = 0; i < 8; i++) add(8'h10 + 8'(8'h11 * i), 1'b1, 0, 1, 0, (i == 7) ? 1 : 0);
        // Three good bytes, byte 3 with stop=0, 1 bit of idle, then 0xA0..0xA7
        for (int i = 0; i < 3; i++) add(8'hB0 + 8'(i), 1'b1, 0, 1, 0, 0);
        add(8'hB3, 1'b0, 1, 0, 1, 0);
        for (int i = 0; i < 8; i++) add(8'hA0 + 8'(i), 1'b1, 0, 1, 0, (i == 7) ? 1 : 0);
        // Five bytes, 13 bit-times idle, then 0x01..0x08
        for (int i = 0; i < 5; i++) add(8'hC0 + 8'(i), 1'b1, (i == 4) ? 13 : 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) add(8'h01 + 8'(i), 1'b1, 0, 1, 0, (i == 7) ? 1 : 0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_d", d_word(), 64'd0);
        check("rst_byte_data", 64'(bus.byte_data), 64'd0);
        check("rst_byte_valid", 64'(bus.byte_valid), 64'd0);
        check("rst_frame_valid", 64'(bus.frame_valid), 64'd0);
        check("rst_frame_err", 64'(bus.frame_err), 64'd0);
        check("rst_state", 64'(dut.u_byte.state), 64'(IDLE));
        rst = 1'b0;
        idle_bits(2);

        // Glitch: 3 cycles low, well under half a bit
        bv0 = n_bv; err0 = n_err;
        #1 UART_rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 UART_rx = 1'b1;
        repeat (B / 2 + 6) @(posedge clk);
        #1;
        check("glitch_state_idle", 64'(dut.u_byte.state), 64'(IDLE));
        check("glitch_no_bv", 64'(n_bv - bv0), 64'd0);
        check("glitch_no_err", 64'(n_err - err0), 64'd0);
        idle_bits(2);

        // Table-driven byte stream
        for (int i = 0; i < vecs.size(); i++) begin
            bv0 = n_bv; fv0 = n_fv; err0 = n_err;
            send_byte(vecs[i].data, vecs[i].stop);
            idle_bits(vecs[i].gap_bits);
            check($sformatf("v%0d_bv", i), 64'(n_bv - bv0), 64'(vecs[i].exp_bv));
            check($sformatf("v%0d_err", i), 64'(n_err - err0), 64'(vecs[i].exp_err));
            check($sformatf("v%0d_fv", i), 64'(n_fv - fv0), 64'(vecs[i].exp_fv));
            if (vecs[i].exp_bv != 0)
                check($sformatf("v%0d_byte", i), 64'(bus.byte_data), 64'(vecs[i].data));
            if (vecs[i].exp_fv != 0) begin
                for (int k = 0; k < 8; k++) exp_d[8*k +: 8] = vecs[i - 7 + k].data;
                check($sformatf("v%0d_frame", i), d_word(), exp_d);
            end
        end
        idle_bits(2);

        // Loopback-style stream: misaligned partial, realign, two full frames
        for (int k = 0; k < 8; k++) exp_d[8*k +: 8] = 8'h10 + 8'(8'h11 * k);
        fv0 = n_fv; err0 = n_err;
        for (int k = 0; k < 3; k++) send_byte(exp_d[8*k +: 8], 1'b1);
        idle_bits(13);
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 8; k++) send_byte(exp_d[8*k +: 8], 1'b1);
            check($sformatf("lb%0d_fv", f), 64'(n_fv - fv0), 64'(f + 1));
            check($sformatf("lb%0d_frame", f), d_word(), exp_d);
        end
        check("lb_no_err", 64'(n_err - err0), 64'd0);
        idle_bits(2);

        // Reset during data bit 4 of byte 2
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        b = 8'h33;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(b[i]);
        #1 UART_rx = b[4];
        repeat (B / 2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_d", d_word(), 64'd0);
        check("midrst_byte_data", 64'(bus.byte_data), 64'd0);
        check("midrst_bv", 64'(bus.byte_valid), 64'd0);
        check("midrst_fv", 64'(bus.frame_valid), 64'd0);
        check("midrst_err", 64'(bus.frame_err), 64'd0);
        check("midrst_state", 64'(dut.u_byte.state), 64'(IDLE));
        UART_rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle_bits(2);
        fv0 = n_fv; bv0 = n_bv;
        for (int k = 0; k < 8; k++) send_byte(8'h55, 1'b1);
        check("post_rst_bv", 64'(n_bv - bv0), 64'd8);
        check("post_rst_fv", 64'(n_fv - fv0), 64'd1);
        check("post_rst_frame", d_word(), {8{8'h55}});
        idle_bits(2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
